// File: rtl/mic_packet_tx.sv
// mic_packet_tx: queues 32-bit mu-law words from the mic packer and serializes each as a
// 40-bit {HDR, word} packet on an arbiter grant. Optional feature macro: MICTX_SILENCE_PAD_EN.
module mic_packet_tx #(
    parameter int         DEPTH    = 4,
    parameter logic [7:0] HDR      = 8'hC0,
    parameter int         GAP_BITS = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_record_active,
    input  logic [31:0]             i_mic_data,
    input  logic                    i_mic_data_valid,
    output logic                    o_mic_data_retrieved,
    input  logic                    i_slot_grant,
    input  logic                    i_bit_en,
    output logic                    o_tx_req,
    output logic                    o_tx_data,
    output logic                    o_tx_frame,
    output logic [$clog2(DEPTH):0]  o_fifo_level,
    output logic [7:0]              o_drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];
    localparam logic [5:0]  LAST_BIT   = 6'd39;
    localparam logic [7:0]  GAP_LAST   = 8'(GAP_BITS - 1);

    // state     | meaning
    // S_IDLE    | line idle, waiting for queued data
    // S_WAIT    | tx_req up, waiting for slot_grant
    // S_SEND    | shifting out the 40 packet bits
    // S_GAP     | idle line for GAP_BITS bit times
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          r_retrieved;
    logic [7:0]    r_drop_cnt;
    logic [1:0]    r_state;
    logic [39:0]   r_shift;
    logic [5:0]    r_bit_cnt;
    logic [7:0]    r_gap_cnt;
    logic          r_tx_req;
    logic          r_tx_frame;

    logic          w_empty;
    logic          w_full;
    logic          w_capture;
    logic          w_load;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_start;
    logic [31:0]   w_payload;

    assign w_empty   = (r_level == '0);
    assign w_full    = (r_level == FULL_LEVEL);
    assign w_capture = i_record_active && i_mic_data_valid && !r_retrieved;
    assign w_load    = (r_state == S_WAIT) && i_record_active && i_slot_grant;
    assign w_pop     = w_load && !w_empty;
    // a pop on the same edge frees the slot, so a full FIFO still accepts the word
    assign w_push    = w_capture && (!w_full || w_pop);
    assign w_drop    = w_capture && w_full && !w_pop;

`ifdef MICTX_SILENCE_PAD_EN
    assign w_payload = w_empty ? 32'hFFFF_FFFF : r_mem[r_rd_ptr];
    assign w_start   = i_record_active;
`else
    assign w_payload = r_mem[r_rd_ptr];
    assign w_start   = i_record_active && !w_empty;
`endif

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_mic_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_retrieved <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_retrieved <= w_capture;
            if (!i_record_active) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                if (w_push && !w_pop)      r_level <= r_level + 1'b1;
                else if (!w_push && w_pop) r_level <= r_level - 1'b1;
            end
            if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_tx_req   <= 1'b0;
            r_tx_frame <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state  <= S_WAIT;
                        r_tx_req <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (!i_record_active) begin
                        r_state  <= S_IDLE;
                        r_tx_req <= 1'b0;
                    end else if (i_slot_grant) begin
                        r_shift    <= {HDR, w_payload};
                        r_bit_cnt  <= LAST_BIT;
                        r_tx_req   <= 1'b0;
                        r_tx_frame <= 1'b1;
                        r_state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    // 40 shifts leave the register all-zero, so tx_data idles low
                    if (i_bit_en) begin
                        r_shift <= {r_shift[38:0], 1'b0};
                        if (r_bit_cnt == '0) begin
                            r_tx_frame <= 1'b0;
                            r_gap_cnt  <= GAP_LAST;
                            r_state    <= S_GAP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt - 6'd1;
                        end
                    end
                end
                S_GAP: begin
                    if (i_bit_en) begin
                        if (r_gap_cnt == '0) r_state <= S_IDLE;
                        else                 r_gap_cnt <= r_gap_cnt - 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_mic_data_retrieved = r_retrieved;
    assign o_tx_req             = r_tx_req;
    assign o_tx_data            = r_shift[39];
    assign o_tx_frame           = r_tx_frame;
    assign o_fifo_level         = r_level;
    assign o_drop_cnt           = r_drop_cnt;
endmodule
